// File: rtl/timer_irq_snapshot_master.sv
// Avalon-MM master that services interval-timer irqs and queues {snap_h, snap_l} events tagged with a wrapping sequence number.
// Optional build macro DROP_COUNT_EN adds a saturating drop_count output.
module timer_irq_snapshot_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_W      = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        timer_irq,
    output logic [2:0]                  tmr_address,
    output logic                        tmr_chipselect,
    output logic                        tmr_write_n,
    output logic [15:0]                 tmr_writedata,
    input  logic [15:0]                 tmr_readdata,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [31:0]                 evt_data,
    output logic [SEQ_W-1:0]            evt_seq,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef DROP_COUNT_EN
    ,
    output logic [15:0]                 drop_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // IDLE wait | CLR clear status | SNAP latch counter | RDL address snap_l | WL take lo | WH take hi | PUSH enqueue
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SNAP,
        S_RDL,
        S_WL,
        S_WH,
        S_PUSH
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_lo;
    logic [15:0]        r_hi;
    logic [SEQ_W-1:0]   r_seq;
    logic [31:0]        r_mem_data [FIFO_DEPTH];
    logic [SEQ_W-1:0]   r_mem_seq  [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'd0;
        case (r_state)
            S_IDLE: begin
                if (timer_irq && enable) begin
                    w_next = S_CLR;
                end
            end
            S_CLR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                w_next         = S_SNAP;
            end
            S_SNAP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd4;
                w_next         = S_RDL;
            end
            S_RDL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd4;
                w_next         = S_WL;
            end
            S_WL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd5;
                w_next         = S_WH;
            end
            S_WH: begin
                w_next = S_PUSH;
            end
            S_PUSH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Read data lags the address by one cycle, so each half lands in the state after its read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lo <= 16'd0;
            r_hi <= 16'd0;
        end else begin
            if (r_state == S_WL) begin
                r_lo <= tmr_readdata;
            end
            if (r_state == S_WH) begin
                r_hi <= tmr_readdata;
            end
        end
    end

    assign w_push   = (r_state == S_PUSH);
    assign w_pop    = (r_level != '0) && evt_ready;
    assign w_full   = (r_level == LVL_FULL);
    assign w_accept = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seq    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is not reset; the outputs are gated by occupancy instead.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_data[r_wr_ptr] <= {r_hi, r_lo};
            r_mem_seq[r_wr_ptr]  <= r_seq;
        end
    end

    assign evt_valid  = (r_level != '0);
    assign evt_data   = evt_valid ? r_mem_data[r_rd_ptr] : 32'd0;
    assign evt_seq    = evt_valid ? r_mem_seq[r_rd_ptr] : '0;
    assign fifo_level = r_level;

`ifdef DROP_COUNT_EN
    logic [15:0] r_drop_count;
    logic        w_drop;

    assign w_drop = w_push && !w_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= 16'd0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule
